// File: rtl/t01_screen_pkg.sv
// Shared screen-sequencer types: screen states, colour constants and default frame timings.
package t01_screen_pkg;

  typedef enum logic [1:0] {
    TITLE     = 2'd0,
    COUNTDOWN = 2'd1,
    GAME      = 2'd2,
    OVER      = 2'd3
  } screen_t;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  localparam int DEF_COUNT_FRAMES = 60;
  localparam int DEF_HOLD_FRAMES  = 120;
  localparam int DEF_BLINK_LOG2   = 5;

endpackage

// File: rtl/t01_frame_timer.sv
// 8-bit per-state frame counter: synchronous clear, frame-tick enable, optional saturation.
module t01_frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic       sat_en,
  input  logic [7:0] sat_val,
  output logic [7:0] count
);

  // Clear beats the tick so a transition never counts the frame it happens on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (tick && !(sat_en && (count >= sat_val))) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/t01_screen_sequencer.sv
// Screen controller: title/countdown/play/game-over sequencing and VGA colour selection.
module t01_screen_sequencer
  import t01_screen_pkg::*;
#(
  parameter int COUNT_FRAMES = DEF_COUNT_FRAMES,
  parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
  parameter int BLINK_LOG2   = DEF_BLINK_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [2:0] title_color,
  input  logic [2:0] game_color,
  input  logic [2:0] over_color,
  output logic [2:0] shape_color,
  output logic [1:0] mode,
  output logic       game_en,
  output logic [1:0] countdown,
  output logic       blink_on
);

  localparam logic [7:0] CD_ONE  = 8'(COUNT_FRAMES);
  localparam logic [7:0] CD_TWO  = 8'(2 * COUNT_FRAMES);
  localparam logic [7:0] CD_LAST = 8'(3 * COUNT_FRAMES - 1);
  localparam logic [7:0] HOLD    = 8'(HOLD_FRAMES);

  screen_t               state;
  logic [7:0]            cnt;
  logic [BLINK_LOG2:0]   blink_cnt;
  logic                  go_countdown, go_game, go_over, go_title;
  logic [2:0]            pix_sel;

  assign go_countdown = (state == TITLE) && start_btn;
  assign go_game      = (state == COUNTDOWN) && frame_tick && (cnt == CD_LAST);
  assign go_over      = (state == GAME) && game_over;
  assign go_title     = (state == OVER) && start_btn && (cnt >= HOLD);

  t01_frame_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (go_countdown | go_game | go_over | go_title),
    .tick    (frame_tick && ((state == COUNTDOWN) || (state == OVER))),
    .sat_en  (state == OVER),
    .sat_val (HOLD),
    .count   (cnt)
  );

  // Transparent game-over text lets the frozen playfield show through.
  always_comb begin
    pix_sel = game_color;
    case (state)
      TITLE:   pix_sel = title_color;
      OVER:    pix_sel = (over_color != BLACK) ? over_color : game_color;
      default: pix_sel = game_color;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= TITLE;
      shape_color <= BLACK;
    end else begin
      shape_color <= pix_sel;
      case (state)
        TITLE:     if (go_countdown) state <= COUNTDOWN;
        COUNTDOWN: if (go_game)      state <= GAME;
        GAME:      if (go_over)      state <= OVER;
        OVER:      if (go_title)     state <= TITLE;
        default:                     state <= TITLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
    end else if (frame_tick) begin
      blink_cnt <= blink_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    countdown = 2'd0;
    if (state == COUNTDOWN) begin
      if (cnt < CD_ONE)      countdown = 2'd3;
      else if (cnt < CD_TWO) countdown = 2'd2;
      else                   countdown = 2'd1;
    end
  end

  assign mode     = state;
  assign game_en  = (state == GAME);
  assign blink_on = blink_cnt[BLINK_LOG2];

endmodule

// File: tb/tb_t01_screen_sequencer.sv
// Directed bench for t01_screen_sequencer with hand-computed expectations.
module tb_t01_screen_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, start_btn, game_over;
  logic [2:0] title_color, game_color, over_color;
  logic [2:0] shape_color;
  logic [1:0] mode;
  logic       game_en;
  logic [1:0] countdown;
  logic       blink_on;

  int total = 0;
  int bad   = 0;
  int nticks = 0;

  t01_screen_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .game_over   (game_over),
    .title_color (title_color),
    .game_color  (game_color),
    .over_color  (over_color),
    .shape_color (shape_color),
    .mode        (mode),
    .game_en     (game_en),
    .countdown   (countdown),
    .blink_on    (blink_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
    nticks += n;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  function automatic logic exp_blink();
    return logic'((nticks >> 5) & 1);
  endfunction

  initial begin
    rst = 1'b0;
    frame_tick = 1'b0; start_btn = 1'b0; game_over = 1'b0;
    title_color = 3'b100; game_color = 3'b111; over_color = 3'b000;
    step();
    chk("rst_mode", mode, 0);
    chk("rst_shape", shape_color, 0);
    chk("rst_game_en", game_en, 0);
    chk("rst_cd", countdown, 0);
    chk("rst_blink", blink_on, 0);

    rst = 1'b1;
    step();
    chk("title_mode", mode, 0);
    chk("title_shape", shape_color, 3'b100);
    chk("title_game_en", game_en, 0);

    // start coincident with a tick: counter must not count that tick
    start_btn = 1'b1; frame_tick = 1'b1;
    step();
    start_btn = 1'b0; frame_tick = 1'b0; nticks++;
    chk("cd_mode", mode, 1);
    chk("cd_digit3", countdown, 3);
    step();
    chk("cd_shape", shape_color, 3'b111);
    chk("cd_game_en", game_en, 0);
    pulse_start();
    chk("cd_start_ign", mode, 1);
    game_over = 1'b1; step(); game_over = 1'b0;
    chk("cd_over_ign", mode, 1);

    tick(59);
    chk("cd_59", countdown, 3);
    tick(1);
    chk("cd_60", countdown, 2);
    tick(60);
    chk("cd_120", countdown, 1);
    chk("blink_a", blink_on, exp_blink());
    tick(59);
    chk("cd_179_mode", mode, 1);
    tick(1);
    chk("game_mode", mode, 2);
    chk("game_en", game_en, 1);
    chk("game_cd0", countdown, 0);
    chk("blink_b", blink_on, exp_blink());

    pulse_start();
    chk("game_start_ign", mode, 2);
    chk("game_shape", shape_color, 3'b111);

    game_over = 1'b1; start_btn = 1'b1;
    step();
    game_over = 1'b0; start_btn = 1'b0;
    chk("over_mode", mode, 3);
    chk("over_game_en", game_en, 0);
    step();
    chk("over_transp", shape_color, 3'b111);
    over_color = 3'b100;
    step();
    chk("over_text", shape_color, 3'b100);

    tick(50);
    pulse_start();
    chk("over_hold50", mode, 3);
    tick(69);
    pulse_start();
    chk("over_hold119", mode, 3);
    tick(1);
    chk("blink_c", blink_on, exp_blink());
    pulse_start();
    chk("over_exit", mode, 0);
    step();
    chk("title_again", shape_color, 3'b100);

    pulse_start();
    tick(5);
    chk("cd2_mode", mode, 1);
    rst = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_cd", countdown, 0);
    chk("arst_shape", shape_color, 0);
    chk("arst_blink", blink_on, 0);
    chk("arst_game_en", game_en, 0);
    nticks = 0;
    #2;
    rst = 1'b1;
    step();
    tick(31);
    chk("blink_31", blink_on, 0);
    tick(1);
    chk("blink_32", blink_on, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
